// File: rtl/jtaglet_host.sv
`default_nettype none
// ============================================================================
// Module   : jtaglet_host
// Purpose  : JTAG host; turns scan/reset/idle commands into tck_o/tms_o/tdi_o
//            activity and returns captured TDO. Define JTAGLET_HOST_TRST_EN
//            to add an active-low trst_o pin pulsed by TAP-reset commands.
// Revision : 1.0  initial release
// ============================================================================
module jtaglet_host #(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = 6,
   parameter int CLK_DIV = 2
) (
   input  logic               tck,
   input  logic               trst,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_type,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               rsp_err,
   output logic               tck_o,
   output logic               tms_o,
   output logic               tdi_o,
   input  logic               tdo_i
`ifdef JTAGLET_HOST_TRST_EN
   ,output logic              trst_o
`endif
);

   localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
   localparam logic [LEN_W-1:0]   c_MAX_LEN  = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0]   c_TLR_ONES = LEN_W'(5);
   localparam logic [LEN_W-1:0]   c_PON_LAST = LEN_W'(5);
`ifdef JTAGLET_HOST_TRST_EN
   localparam logic [LEN_W-1:0]   c_CMD_RST_LAST = LEN_W'(6);
`else
   localparam logic [LEN_W-1:0]   c_CMD_RST_LAST = LEN_W'(5);
`endif

   typedef enum logic [2:0] {
      RESET_SEQ = 3'd0,
      IDLE      = 3'd1,
      SEL       = 3'd2,
      SHIFT     = 3'd3,
      EXIT      = 3'd4,
      RUN       = 3'd5,
      RESP      = 3'd6
   } state_t;

   state_t               r_state, w_state_nx;
   logic [LEN_W-1:0]     r_cnt, w_cnt_nx, w_cnt_inc;
   logic [LEN_W-1:0]     r_shift, w_shift_nx;
   logic [LEN_W-1:0]     r_len, w_len_nx;
   logic                 r_tms, w_tms_nx;
   logic                 r_tdi, w_tdi_nx;
   logic [MAX_LEN-1:0]   r_tdi_sr, w_tdi_sr_nx;
   logic [MAX_LEN-1:0]   r_rsp, w_rsp_nx;
   logic                 r_err, w_err_nx;
   logic                 r_is_ir, w_is_ir_nx;
   logic                 r_cmd_rst, w_cmd_rst_nx;
   logic                 r_tck;
   logic [c_DIV_W-1:0]   r_div;
   logic                 w_active, w_div_done, w_rise, w_fall, w_bad_len;

   assign w_active   = (r_state == RESET_SEQ) || (r_state == SEL) || (r_state == SHIFT) ||
                       (r_state == EXIT) || (r_state == RUN);
   assign w_div_done = (r_div == c_DIV_LAST);
   assign w_rise     = w_active && !r_tck && w_div_done;
   // A JTAG cycle ends on the clock that drops tck_o; that is where TMS/TDI advance.
   assign w_fall     = w_active && r_tck && w_div_done;
   assign w_cnt_inc  = r_cnt + 1'b1;
   assign w_bad_len  = (cmd_len == '0) || (cmd_len > c_MAX_LEN);

   always_ff @(posedge tck or negedge trst) begin
      if (!trst) begin
         r_state   <= RESET_SEQ;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_len     <= '0;
         r_tms     <= 1'b1;
         r_tdi     <= 1'b0;
         r_tdi_sr  <= '0;
         r_rsp     <= '0;
         r_err     <= 1'b0;
         r_is_ir   <= 1'b0;
         r_cmd_rst <= 1'b0;
         r_tck     <= 1'b0;
         r_div     <= '0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_shift   <= w_shift_nx;
         r_len     <= w_len_nx;
         r_tms     <= w_tms_nx;
         r_tdi     <= w_tdi_nx;
         r_tdi_sr  <= w_tdi_sr_nx;
         r_rsp     <= w_rsp_nx;
         r_err     <= w_err_nx;
         r_is_ir   <= w_is_ir_nx;
         r_cmd_rst <= w_cmd_rst_nx;
         if (w_active) begin
            r_div <= w_div_done ? '0 : r_div + 1'b1;
            if (w_div_done) r_tck <= ~r_tck;
         end else begin
            r_div <= '0;
            r_tck <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_shift_nx   = r_shift;
      w_len_nx     = r_len;
      w_tms_nx     = r_tms;
      w_tdi_nx     = r_tdi;
      w_tdi_sr_nx  = r_tdi_sr;
      w_rsp_nx     = r_rsp;
      w_err_nx     = r_err;
      w_is_ir_nx   = r_is_ir;
      w_cmd_rst_nx = r_cmd_rst;
      // TDO enters at the MSB; it is right-aligned once the scan completes.
      if (w_rise && (r_state == SHIFT)) w_rsp_nx = {tdo_i, r_rsp[MAX_LEN-1:1]};
      case (r_state)
         RESET_SEQ: if (w_fall) begin
            if (r_cnt == (r_cmd_rst ? c_CMD_RST_LAST : c_PON_LAST)) begin
               w_state_nx   = r_cmd_rst ? RESP : IDLE;
               w_cnt_nx     = '0;
               w_tms_nx     = 1'b0;
               w_cmd_rst_nx = 1'b0;
            end else begin
               w_cnt_nx = w_cnt_inc;
               w_tms_nx = (w_cnt_inc < c_TLR_ONES);
            end
         end
         IDLE: if (cmd_valid) begin
            w_len_nx    = cmd_len;
            w_tdi_sr_nx = cmd_data;
            w_rsp_nx    = '0;
            w_err_nx    = 1'b0;
            w_cnt_nx    = '0;
            w_tdi_nx    = 1'b0;
            case (cmd_type)
               2'b00, 2'b01: begin
                  if (w_bad_len) begin
                     w_state_nx = RESP;
                     w_err_nx   = 1'b1;
                  end else begin
                     w_state_nx = SEL;
                     w_tms_nx   = 1'b1;
                     w_is_ir_nx = cmd_type[0];
                  end
               end
               2'b10: begin
                  w_state_nx   = RESET_SEQ;
                  w_tms_nx     = 1'b1;
                  w_cmd_rst_nx = 1'b1;
               end
               default: begin
                  if (cmd_len == '0) begin
                     w_state_nx = RESP;
                  end else begin
                     w_state_nx = RUN;
                     w_shift_nx = cmd_len - 1'b1;
                     w_tms_nx   = 1'b0;
                  end
               end
            endcase
         end
         SEL: if (w_fall) begin
            if (r_cnt == (r_is_ir ? LEN_W'(3) : LEN_W'(2))) begin
               w_state_nx  = SHIFT;
               w_shift_nx  = r_len - 1'b1;
               w_tms_nx    = (r_len == LEN_W'(1));
               w_tdi_nx    = r_tdi_sr[0];
               w_tdi_sr_nx = {1'b0, r_tdi_sr[MAX_LEN-1:1]};
            end else begin
               w_cnt_nx = w_cnt_inc;
               w_tms_nx = r_is_ir && (w_cnt_inc < LEN_W'(2));
            end
         end
         SHIFT: if (w_fall) begin
            if (r_shift == '0) begin
               w_state_nx = EXIT;
               w_cnt_nx   = '0;
               w_tms_nx   = 1'b1;
               w_tdi_nx   = 1'b0;
            end else begin
               w_shift_nx  = r_shift - 1'b1;
               w_tms_nx    = (r_shift == LEN_W'(1));
               w_tdi_nx    = r_tdi_sr[0];
               w_tdi_sr_nx = {1'b0, r_tdi_sr[MAX_LEN-1:1]};
            end
         end
         EXIT: if (w_fall) begin
            if (r_cnt == '0) begin
               w_cnt_nx = LEN_W'(1);
               w_tms_nx = 1'b0;
            end else begin
               w_state_nx = RESP;
               w_rsp_nx   = r_rsp >> (MAX_LEN - int'(r_len));
            end
         end
         RUN: if (w_fall) begin
            if (r_shift == '0) w_state_nx = RESP;
            else               w_shift_nx = r_shift - 1'b1;
         end
         RESP: if (rsp_ready) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

`ifdef JTAGLET_HOST_TRST_EN
   logic r_trst_o;
   always_ff @(posedge tck or negedge trst) begin
      if (!trst) r_trst_o <= 1'b0;
      else       r_trst_o <= !((w_state_nx == RESET_SEQ) && w_cmd_rst_nx);
   end
   assign trst_o = r_trst_o;
`endif

   assign cmd_ready = (r_state == IDLE);
   assign rsp_valid = (r_state == RESP);
   assign rsp_data  = r_rsp;
   assign rsp_err   = r_err;
   assign tck_o     = r_tck;
   assign tms_o     = r_tms;
   assign tdi_o     = r_tdi;

endmodule
`default_nettype wire

// File: tb/tb_jtaglet_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtaglet_host
// Purpose  : Scoreboard bench for jtaglet_host looped back to a 4-bit-IR TAP
//            model (IDCODE 0xE, USER 0x8, BYPASS 0xF).
// Revision : 1.0  initial release
// ============================================================================
module tb_jtaglet_host;

   localparam int          c_MAX_LEN = 32;
   localparam int          c_LEN_W   = 6;
   localparam logic [31:0] c_IDCODE  = 32'h4BA00477;
   localparam logic [1:0]  c_DR = 2'b00, c_IR = 2'b01, c_RST = 2'b10, c_IDL = 2'b11;
`ifdef JTAGLET_HOST_TRST_EN
   localparam int          c_RST_RISES = 7;
`else
   localparam int          c_RST_RISES = 6;
`endif

   logic                 tck = 1'b0;
   logic                 trst = 1'b1;
   logic                 cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
   logic [1:0]           cmd_type;
   logic [c_LEN_W-1:0]   cmd_len;
   logic [c_MAX_LEN-1:0] cmd_data, rsp_data;
   logic                 tck_o, tms_o, tdi_o;
   logic                 tdo_i = 1'b0;
`ifdef JTAGLET_HOST_TRST_EN
   logic                 trst_o;
`endif

   jtaglet_host #(.MAX_LEN(c_MAX_LEN), .LEN_W(c_LEN_W), .CLK_DIV(2)) u_dut (
      .tck(tck), .trst(trst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
      .cmd_len(cmd_len), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .tdo_i(tdo_i)
`ifdef JTAGLET_HOST_TRST_EN
      ,.trst_o(trst_o)
`endif
   );

   always #5 tck = ~tck;

   // Reference TAP: actions on the rising tck_o edge, TDO launched on the falling edge.
   localparam int T_TLR = 0, T_RTI = 1, T_SDR = 2, T_CDR = 3, T_SHDR = 4, T_E1DR = 5,
                  T_PDR = 6, T_E2DR = 7, T_UDR = 8, T_SIR = 9, T_CIR = 10, T_SHIR = 11,
                  T_E1IR = 12, T_PIR = 13, T_E2IR = 14, T_UIR = 15;
   int          tap_st = T_TLR;
   logic [3:0]  tap_ir = 4'hE;
   logic [3:0]  tap_ir_sr = 4'h0;
   logic [31:0] tap_dr = 32'h0;
   logic [31:0] tap_user = 32'h0;

   function automatic int tap_next(input int s, input logic m);
      case (s)
         T_TLR:  return m ? T_TLR  : T_RTI;
         T_RTI:  return m ? T_SDR  : T_RTI;
         T_SDR:  return m ? T_SIR  : T_CDR;
         T_CDR:  return m ? T_E1DR : T_SHDR;
         T_SHDR: return m ? T_E1DR : T_SHDR;
         T_E1DR: return m ? T_UDR  : T_PDR;
         T_PDR:  return m ? T_E2DR : T_PDR;
         T_E2DR: return m ? T_UDR  : T_SHDR;
         T_UDR:  return m ? T_SDR  : T_RTI;
         T_SIR:  return m ? T_TLR  : T_CIR;
         T_CIR:  return m ? T_E1IR : T_SHIR;
         T_SHIR: return m ? T_E1IR : T_SHIR;
         T_E1IR: return m ? T_UIR  : T_PIR;
         T_PIR:  return m ? T_E2IR : T_PIR;
         T_E2IR: return m ? T_UIR  : T_SHIR;
         default: return m ? T_SDR : T_RTI;
      endcase
   endfunction

   always @(posedge tck_o) begin
      case (tap_st)
         T_TLR:  tap_ir = 4'hE;
         T_CDR:  tap_dr = (tap_ir == 4'hE) ? c_IDCODE : (tap_ir == 4'h8) ? tap_user : 32'h0;
         T_SHDR: tap_dr = (tap_ir == 4'hF) ? {31'h0, tdi_o} : {tdi_o, tap_dr[31:1]};
         T_UDR:  if (tap_ir == 4'h8) tap_user = tap_dr;
         T_CIR:  tap_ir_sr = 4'b0001;
         T_SHIR: tap_ir_sr = {tdi_o, tap_ir_sr[3:1]};
         T_UIR:  tap_ir = tap_ir_sr;
         default: ;
      endcase
      tap_st = tap_next(tap_st, tms_o);
   end

   always @(negedge tck_o)
      tdo_i = (tap_st == T_SHDR) ? tap_dr[0] : (tap_st == T_SHIR) ? tap_ir_sr[0] : 1'b0;

   int          rise_cnt = 0;
   logic [31:0] tms_hist = 32'h0;
   time         last_rise = 0;
   time         rise_period = 0;
   always @(posedge tck_o) begin
      rise_cnt    = rise_cnt + 1;
      tms_hist    = {tms_hist[30:0], tms_o};
      rise_period = $time - last_rise;
      last_rise   = $time;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_vec++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
      end
   endtask

   typedef struct {
      string       tag;
      logic        err;
      logic [31:0] data;
      int          rises;
   } exp_t;
   exp_t sb[$];

   task automatic wait_ready(input string tag);
      int k = 0;
      while (!cmd_ready && k < 500) begin
         @(negedge tck);
         k++;
      end
      check_eq({tag, "_ready"}, cmd_ready, 1);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_tck_o"}, tck_o, 0);
      check_eq({tag, "_tms_o"}, tms_o, 1);
      check_eq({tag, "_tdi_o"}, tdi_o, 0);
      check_eq({tag, "_cmd_ready"}, cmd_ready, 0);
      check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
      check_eq({tag, "_rsp_err"}, rsp_err, 0);
      check_eq({tag, "_rsp_data"}, rsp_data, 0);
   endtask

   task automatic check_tlr(input string tag, input int r0);
      wait_ready(tag);
      check_eq({tag, "_rises"}, rise_cnt - r0, 6);
      check_eq({tag, "_tms_seq"}, tms_hist[5:0], 6'b111110);
      check_eq({tag, "_tck_period"}, rise_period, 40);
      check_eq({tag, "_tap_rti"}, tap_st, T_RTI);
   endtask

   task automatic run_cmd(input logic [1:0] t, input logic [c_LEN_W-1:0] l,
                          input logic [31:0] d, input logic e_err, input logic [31:0] e_data,
                          input int e_rises, input string tag, input bit early, input int hold);
      exp_t e;
      int   r0;
      int   k;
      e.tag = tag; e.err = e_err; e.data = e_data; e.rises = e_rises;
      wait_ready(tag);
      sb.push_back(e);
      r0 = rise_cnt;
      cmd_type = t; cmd_len = l; cmd_data = d; cmd_valid = 1'b1; rsp_ready = early;
      @(negedge tck);
      cmd_valid = 1'b0;
      check_eq({tag, "_busy"}, cmd_ready, 0);
      k = 0;
      while (!rsp_valid && k < 3000) begin
         @(negedge tck);
         k++;
      end
      e = sb.pop_front();
      if (!rsp_valid) begin
         check_eq({e.tag, "_rsp_timeout"}, rsp_valid, 1);
      end else begin
         check_eq({e.tag, "_data"}, rsp_data, e.data);
         check_eq({e.tag, "_err"}, rsp_err, e.err);
         check_eq({e.tag, "_rises"}, rise_cnt - r0, e.rises);
         for (int i = 0; i < hold; i++) begin
            @(negedge tck);
            check_eq({e.tag, "_hold_valid"}, rsp_valid, 1);
            check_eq({e.tag, "_hold_data"}, rsp_data, e.data);
            check_eq({e.tag, "_hold_ready"}, cmd_ready, 0);
         end
         rsp_ready = 1'b1;
         if (early) rsp_ready = 1'b1;
         @(negedge tck);
         rsp_ready = 1'b0;
         check_eq({e.tag, "_rsp_done"}, rsp_valid, 0);
         check_eq({e.tag, "_ready_back"}, cmd_ready, 1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int r0;
      cmd_valid = 1'b0; cmd_type = 2'b00; cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
      #1 trst = 1'b0;
      #2 check_reset_values("por");
      repeat (3) @(negedge tck);
      r0 = rise_cnt;
      trst = 1'b1;
      check_tlr("tlr_por", r0);

      run_cmd(c_IR, 6'd4,  32'hE,        1'b0, 32'h1,        10, "ir_idcode", 1'b0, 0);
      run_cmd(c_DR, 6'd32, 32'h0,        1'b0, c_IDCODE,     37, "dr_idcode", 1'b0, 0);
      run_cmd(c_IR, 6'd4,  32'hF,        1'b0, 32'h1,        10, "ir_bypass", 1'b1, 0);
      run_cmd(c_DR, 6'd8,  32'hA5,       1'b0, 32'h4A,       13, "dr_bypass", 1'b0, 0);
      run_cmd(c_IR, 6'd4,  32'h8,        1'b0, 32'h1,        10, "ir_user",   1'b0, 0);
      run_cmd(c_DR, 6'd32, 32'hDEADBEEF, 1'b0, 32'h0,        37, "dr_user_wr", 1'b0, 0);
      check_eq("user_out", tap_user, 32'hDEADBEEF);
      run_cmd(c_DR, 6'd32, 32'h0,        1'b0, 32'hDEADBEEF, 37, "dr_user_rd", 1'b0, 0);
      run_cmd(c_DR, 6'd0,  32'h1234ABCD, 1'b1, 32'h0,         0, "dr_len0",   1'b0, 0);
      run_cmd(c_DR, 6'd33, 32'hFFFFFFFF, 1'b1, 32'h0,         0, "dr_len33",  1'b0, 0);
      run_cmd(c_IR, 6'd63, 32'h5,        1'b1, 32'h0,         0, "ir_len63",  1'b1, 0);
      run_cmd(c_IDL, 6'd3, 32'hFFFFFFFF, 1'b0, 32'h0,         3, "idle3",     1'b0, 0);
      run_cmd(c_IDL, 6'd0, 32'h0,        1'b0, 32'h0,         0, "idle0",     1'b0, 0);
      check_eq("idle_tap_rti", tap_st, T_RTI);
      run_cmd(c_RST, 6'd0, 32'h0,        1'b0, 32'h0, c_RST_RISES, "tap_reset", 1'b0, 0);
      check_eq("tap_reset_tms", tms_hist[5:0], 6'b111110);
      run_cmd(c_DR, 6'd16, 32'h0,        1'b0, c_IDCODE & 32'hFFFF, 21, "dr_hold", 1'b0, 10);

      wait_ready("arst_scan");
      cmd_type = c_DR; cmd_len = 6'd32; cmd_data = 32'h12345678; cmd_valid = 1'b1;
      @(negedge tck);
      cmd_valid = 1'b0;
      repeat (60) @(negedge tck);
      trst = 1'b0;
      #1 check_reset_values("arst");
      @(negedge tck);
      check_eq("arst_no_rsp", rsp_valid, 0);
      r0 = rise_cnt;
      trst = 1'b1;
      check_tlr("tlr_rerun", r0);
      run_cmd(c_DR, 6'd32, 32'h0, 1'b0, c_IDCODE, 37, "dr_after_arst", 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
